// File: rtl/dice_pkg.sv
// Shared types and defaults for the electronic dice front end.
package dice_pkg;

  localparam int unsigned DICE_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DICE_GLITCH_W        = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } debounce_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs on the dice board.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, emit press/release pulses, count rejected bounces.
// The release pulse is named release_pulse because "release" is a reserved word in SystemVerilog.
module button_debounce
  import dice_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DICE_DEBOUNCE_CYCLES,
  parameter int unsigned GLITCH_W        = DICE_GLITCH_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button_raw,
  output logic                button_out,
  output logic                press,
  output logic                release_pulse,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s2;
  logic             glitch_full;
  debounce_state_t  state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_raw),
    .q   (s2)
  );

  assign glitch_full = &glitch_cnt;

  // Stability FSM: a new level must persist for DEBOUNCE_CYCLES wait cycles to be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      button_out    <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      glitch_cnt    <= '0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2) begin
            state <= IDLE;
            if (!glitch_full) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
          end else if (cnt == CNT_LAST) begin
            state      <= HELD;
            button_out <= 1'b1;
            press      <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (s2) begin
            state <= HELD;
            if (!glitch_full) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            button_out    <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: segment table, async-reset and saturation sequences, random bounce vs run-length model.
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       button_raw;
  logic       out0, press0, rel0;
  logic [7:0] glitch0;
  logic       out1, press1, rel1;
  logic [1:0] glitch1;

  int checks = 0;
  int errors = 0;

  // Model state per instance (0: DEBOUNCE_CYCLES=4, GLITCH_W=8; 1: DEBOUNCE_CYCLES=1, GLITCH_W=2)
  int m_s1[2], m_s2[2], m_level[2], m_run[2], m_glitch[2], m_press[2], m_rel[2];
  int press_seen, rel_seen;

  typedef struct {
    logic raw;
    int   len;
    int   out;
    int   presses;
    int   releases;
    int   glitch;
  } seg_t;

  seg_t segs[11];

  button_debounce #(.DEBOUNCE_CYCLES(4), .GLITCH_W(8)) dut0 (
    .clk           (clk),
    .rst           (rst),
    .button_raw    (button_raw),
    .button_out    (out0),
    .press         (press0),
    .release_pulse (rel0),
    .glitch_cnt    (glitch0)
  );

  button_debounce #(.DEBOUNCE_CYCLES(1), .GLITCH_W(2)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .button_raw    (button_raw),
    .button_out    (out1),
    .press         (press1),
    .release_pulse (rel1),
    .glitch_cnt    (glitch1)
  );

  always #5 clk = ~clk;

  function automatic int dc_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int gmax_of(input int i);
    return (i == 0) ? 255 : 3;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_level[i] = 0; m_run[i] = 0;
      m_glitch[i] = 0; m_press[i] = 0; m_rel[i] = 0;
    end
  endtask

  // Run-length view: a level is accepted on its (N+1)th consecutive synchronised sample
  // that differs from the current level; a shorter run that ends is one glitch.
  task automatic model_edge(input int i, input int r);
    int d;
    d = m_s2[i];
    m_press[i] = 0;
    m_rel[i]   = 0;
    if (d != m_level[i]) begin
      m_run[i]++;
      if (m_run[i] == dc_of(i) + 1) begin
        m_level[i] = d;
        m_run[i]   = 0;
        if (d != 0) m_press[i] = 1;
        else        m_rel[i]   = 1;
      end
    end else begin
      if (m_run[i] > 0 && m_glitch[i] < gmax_of(i)) m_glitch[i]++;
      m_run[i] = 0;
    end
    m_s2[i] = m_s1[i];
    m_s1[i] = r;
  endtask

  task automatic compare_all();
    check("out0",    int'(out0),    m_level[0]);
    check("press0",  int'(press0),  m_press[0]);
    check("rel0",    int'(rel0),    m_rel[0]);
    check("glitch0", int'(glitch0), m_glitch[0]);
    check("out1",    int'(out1),    m_level[1]);
    check("press1",  int'(press1),  m_press[1]);
    check("rel1",    int'(rel1),    m_rel[1]);
    check("glitch1", int'(glitch1), m_glitch[1]);
    check("pulse_excl", int'(press0 & rel0) + int'(press1 & rel1), 0);
    press_seen += int'(press0);
    rel_seen   += int'(rel0);
  endtask

  task automatic tick(input logic r);
    button_raw = r;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, int'(r));
    #1;
    compare_all();
  endtask

  initial begin
    segs[0]  = '{raw: 1'b0, len: 4,  out: 0, presses: 0, releases: 0, glitch: 0};
    segs[1]  = '{raw: 1'b1, len: 20, out: 1, presses: 1, releases: 0, glitch: 0};
    segs[2]  = '{raw: 1'b0, len: 20, out: 0, presses: 0, releases: 1, glitch: 0};
    segs[3]  = '{raw: 1'b1, len: 2,  out: 0, presses: 0, releases: 0, glitch: 0};
    segs[4]  = '{raw: 1'b0, len: 1,  out: 0, presses: 0, releases: 0, glitch: 0};
    segs[5]  = '{raw: 1'b1, len: 3,  out: 0, presses: 0, releases: 0, glitch: 1};
    segs[6]  = '{raw: 1'b0, len: 1,  out: 0, presses: 0, releases: 0, glitch: 1};
    segs[7]  = '{raw: 1'b1, len: 20, out: 1, presses: 1, releases: 0, glitch: 2};
    segs[8]  = '{raw: 1'b0, len: 2,  out: 1, presses: 0, releases: 0, glitch: 2};
    segs[9]  = '{raw: 1'b1, len: 10, out: 1, presses: 0, releases: 0, glitch: 3};
    segs[10] = '{raw: 1'b0, len: 20, out: 0, presses: 0, releases: 1, glitch: 3};

    press_seen = 0;
    rel_seen   = 0;
    rst        = 1'b1;
    button_raw = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out",    int'(out0),    0);
    check("reset_press",  int'(press0),  0);
    check("reset_rel",    int'(rel0),    0);
    check("reset_glitch", int'(glitch0), 0);
    rst = 1'b0;

    // Clean press/release, bounces on press, glitch while held
    for (int s = 0; s < 11; s++) begin
      int p0, r0;
      p0 = press_seen;
      r0 = rel_seen;
      for (int k = 0; k < segs[s].len; k++) tick(segs[s].raw);
      check($sformatf("seg%0d_out", s),      int'(out0),     segs[s].out);
      check($sformatf("seg%0d_glitch", s),   int'(glitch0),  segs[s].glitch);
      check($sformatf("seg%0d_presses", s),  press_seen - p0, segs[s].presses);
      check($sformatf("seg%0d_releases", s), rel_seen - r0,   segs[s].releases);
    end

    // Async reset in the middle of PRESS_WAIT, with raw held high through and after reset
    repeat (4) tick(1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("async_out0",    int'(out0),    0);
    check("async_glitch0", int'(glitch0), 0);
    check("async_out1",    int'(out1),    0);
    check("async_press1",  int'(press1),  0);
    model_reset();
    #2;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1);
      check($sformatf("post_rst_press_e%0d", k), int'(press0), (k == 6) ? 1 : 0);
      check($sformatf("post_rst_out_e%0d", k),   int'(out0),   (k >= 6) ? 1 : 0);
    end

    // Saturation of the rejected-bounce counter
    repeat (10) tick(1'b0);
    for (int n = 0; n < 300; n++) begin
      repeat (2) tick(1'b1);
      repeat (3) tick(1'b0);
    end
    check("sat_glitch", int'(glitch0), 255);
    check("sat_out",    int'(out0),    0);
    repeat (8) tick(1'b1);
    check("sat_press_out",    int'(out0),    1);
    check("sat_glitch_hold",  int'(glitch0), 255);
    repeat (8) tick(1'b0);

    // Random bouncy input against the model
    for (int n = 0; n < 400; n++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) tick(lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
